// File: rtl/fpu_normalizer_pkg.sv
// Shared definitions for the fpu_normalizer block and its bench.
//   DEF_W / DEF_LOG2W : default mantissa width and its log2.
//   state_t           : normalizer FSM encoding (IDLE=0, SHIFT=1, DONE=2).
package fpu_normalizer_pkg;

  localparam int DEF_W     = 64;
  localparam int DEF_LOG2W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_norm_stage.sv
// One binary-search step of the normalizer (purely combinational).
// Ports:
//   data    : current working word
//   k       : search step; the probed window is the top 2^k bits
//   shifted : data << 2^k
//   hit     : the top 2^k bits of data are all zero
module fpu_norm_stage
  import fpu_normalizer_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int LOG2W  = DEF_LOG2W,
  parameter int STEP_W = (LOG2W > 1) ? $clog2(LOG2W) : 1
) (
  input  logic [W-1:0]      data,
  input  logic [STEP_W-1:0] k,
  output logic [W-1:0]      shifted,
  output logic              hit
);

  logic [LOG2W:0] amt;
  logic [W-1:0]   hi_mask;

  always_comb begin
    amt     = {{LOG2W{1'b0}}, 1'b1} << k;
    // Ones over the top 2^k bit positions.
    hi_mask = ~({W{1'b1}} >> amt);
    hit     = ((data & hi_mask) == '0);
    shifted = data << amt;
  end

endmodule

// File: rtl/fpu_normalizer.sv
// Iterative mantissa normalizer: finds the left shift that puts a 1 in the
// MSB, one binary-search step per cycle (LOG2W cycles per word).
// Ports:
//   clk, arst            : clock (rising edge), async active-high reset
//   in_valid / in_ready  : input handshake; in_data is the mantissa
//   out_valid / out_ready: output handshake
//   out_data             : normalized word (MSB set unless out_zero)
//   out_cnt              : leading-zero count (W-1 for a zero word)
//   out_zero             : input word was all zeros
// Build option: define FPU_NORM_FAST_ZERO_EN to let a zero word skip the
// search and present its result right after the accept edge.
module fpu_normalizer
  import fpu_normalizer_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LOG2W = DEF_LOG2W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [LOG2W-1:0] out_cnt,
  output logic             out_zero
);

  localparam int STEP_W = (LOG2W > 1) ? $clog2(LOG2W) : 1;
  localparam logic [STEP_W-1:0] STEP_FIRST = STEP_W'(LOG2W - 1);

  state_t              state, state_nxt, accept_state;
  logic [W-1:0]        work, work_nxt, shifted;
  logic [LOG2W-1:0]    cnt, cnt_upd;
  logic [STEP_W-1:0]   step;
  logic                zero_w, hit, accept, in_zero;

  fpu_norm_stage #(.W(W), .LOG2W(LOG2W), .STEP_W(STEP_W)) u_stage (
    .data    (work),
    .k       (step),
    .shifted (shifted),
    .hit     (hit)
  );

  always_comb begin
    in_ready     = (state == IDLE) || ((state == DONE) && out_ready);
    accept       = in_valid && in_ready;
    in_zero      = (in_data == '0);
    accept_state = SHIFT;
`ifdef FPU_NORM_FAST_ZERO_EN
    if (in_zero) accept_state = DONE;
`endif
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = accept_state;
      SHIFT:   if (step == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? accept_state : IDLE;
      default: state_nxt = IDLE;
    endcase

    work_nxt      = hit ? shifted : work;
    cnt_upd       = cnt;
    cnt_upd[step] = cnt[step] | hit;
  end

  assign out_valid = (state == DONE);

  // Search registers and held result registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      step     <= '0;
      zero_w   <= 1'b0;
      out_data <= '0;
      out_cnt  <= '0;
      out_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        work   <= in_data;
        cnt    <= '0;
        step   <= STEP_FIRST;
        zero_w <= in_zero;
`ifdef FPU_NORM_FAST_ZERO_EN
        if (in_zero) begin
          out_data <= '0;
          out_cnt  <= '1;
          out_zero <= 1'b1;
        end
`endif
      end else if (state == SHIFT) begin
        work <= work_nxt;
        cnt  <= cnt_upd;
        // Results are copied out only on the last step, so the outputs keep
        // the previous word's values for the whole search.
        if (step == '0) begin
          out_data <= work_nxt;
          out_cnt  <= cnt_upd;
          out_zero <= zero_w;
        end else begin
          step <= step - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_normalizer.sv
// Scoreboard bench for fpu_normalizer: directed cases, backpressure,
// mid-search reset and randomized words against a leading-zero model.
module tb_fpu_normalizer;
  import fpu_normalizer_pkg::*;

  localparam int W     = DEF_W;
  localparam int LOG2W = DEF_LOG2W;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] data;
    int           cnt;
    logic         zero;
    int           lat;
    int           acc_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             arst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [LOG2W-1:0] out_cnt;
  logic             out_zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t cur;
  bit   seen = 1'b0;
  bit   rand_ready_en = 1'b0;
  logic [W-1:0]     hold_data;
  logic [LOG2W-1:0] hold_cnt;
  logic             hold_zero;

  fpu_normalizer #(.W(W), .LOG2W(LOG2W)) dut (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: count zeros from the MSB down; a zero word reports W-1.
  function automatic exp_t model(input logic [W-1:0] w);
    exp_t e;
    int   lz = 0;
    while (lz < W && w[W-1-lz] == 1'b0) lz++;
    e.word = w;
    e.zero = (lz == W);
    e.cnt  = e.zero ? W - 1 : lz;
    e.data = e.zero ? '0 : (w << lz);
`ifdef FPU_NORM_FAST_ZERO_EN
    e.lat  = e.zero ? 0 : LOG2W;
`else
    e.lat  = LOG2W;
`endif
    e.acc_cyc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    int d = $urandom_range(0, 40);
    if ($urandom_range(0, 19) == 0) return '0;
    for (int i = 0; i < W; i++) w[i] = ($urandom_range(0, 99) >= d);
    return w >> $urandom_range(0, W - 1);
  endfunction

  // Called just after a rising edge; returns the number of edges waited.
  task automatic send(input exp_t e, output int waits);
    logic rdy;
    in_valid = 1'b1;
    in_data  = e.word;
    waits    = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        e.acc_cyc = cyc;
        sb.push_back(e);
        break;
      end
      waits++;
      if (waits > 200) begin
        check("accept_timeout", 64'(waits), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic send_const(input logic [W-1:0] w, input logic [W-1:0] d,
                            input int c, input logic z, input int lat);
    exp_t e;
    int   waits;
    e.word = w; e.data = d; e.cnt = c; e.zero = z; e.lat = lat; e.acc_cyc = 0;
    send(e, waits);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!arst && out_valid) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got data %h cnt %0d, expected none", out_data, out_cnt);
        end else begin
          cur = sb[0];
          check("out_data", out_data, cur.data);
          check("out_cnt", 64'(out_cnt), 64'(cur.cnt));
          check("out_zero", 64'(out_zero), 64'(cur.zero));
          check("latency", 64'(cyc - cur.acc_cyc), 64'(cur.lat));
        end
        hold_data = out_data;
        hold_cnt  = out_cnt;
        hold_zero = out_zero;
        seen      = 1'b1;
      end else begin
        check("hold_data", out_data, hold_data);
        check("hold_cnt", 64'(out_cnt), 64'(hold_cnt));
        check("hold_zero", 64'(out_zero), 64'(hold_zero));
      end
      if (out_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        seen = 1'b0;
      end
    end
  end

  initial begin
    int   waits;
    int   n;
    exp_t e;
`ifdef FPU_NORM_FAST_ZERO_EN
    int zero_lat = 0;
`else
    int zero_lat = LOG2W;
`endif
    arst      = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_cnt", 64'(out_cnt), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    arst = 1'b0;
    @(posedge clk);
    #1;

    // Directed words with hand-computed results
    send_const(64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 63, 1'b0, LOG2W);
    send_const(64'h0000_0000_0001_2345, 64'h91A2_8000_0000_0000, 47, 1'b0, LOG2W);
    send_const(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1'b0, LOG2W);
    send_const(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 63, 1'b1, zero_lat);
    send_const(64'h0000_0000_0000_0003, 64'hC000_0000_0000_0000, 62, 1'b0, LOG2W);
    drain();

    // Backpressure: result held for 10 cycles, then a same-edge accept
    out_ready = 1'b0;
    send(model(64'h00F0_0000_1234_0000), waits);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_valid_rise", 64'(out_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(model(64'h0000_0F0F_0000_0001), waits);
    check("bp_same_edge_accept", 64'(waits), 64'd0);
    drain();

    // Reset while the search is at step 3
    send(model(64'h0000_0F00_0000_0000), waits);
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    check("mid_rst_out_cnt", 64'(out_cnt), 64'd0);
    check("mid_rst_out_zero", 64'(out_zero), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    seen = 1'b0;
    @(posedge clk);
    #1;
    arst = 1'b0;
    @(posedge clk);
    #1;
    send(model(64'h0000_0000_0000_0300), waits);
    drain();

    // Randomized words with random output stalls
    rand_ready_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      e = model(rand_word());
      send(e, waits);
    end
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
